alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle command sequencer that drives a shared combinational ALU.
// Optional macro ALU_SEQ_MUL_EN adds the shift-and-add MUL command (opcode 10).
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_ans
);

  localparam int         DATA_W  = 16;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL1 = 4'd6;
  localparam logic [3:0] OP_SRA1 = 4'd7;
  localparam logic [3:0] OP_SLLN = 4'd8;
  localparam logic [3:0] OP_SRAN = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cmd;
  logic [DATA_W-1:0] w;      // working register: A, shift value or MUL accumulator
  logic [DATA_W-1:0] opb;    // B operand, or the shifting multiplicand for MUL
  logic [DATA_W-1:0] w_nxt;
  logic [4:0]        cnt;    // EXEC cycles remaining, including the current one
`ifdef ALU_SEQ_MUL_EN
  logic [DATA_W-1:0] q;
`endif

  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_SRAN);
`endif
  endfunction

  // A zero shift count still spends one EXEC cycle passing A through the adder.
  function automatic logic [4:0] op_iters(input logic [3:0] op, input logic [3:0] shamt);
    if (op == OP_SLLN || op == OP_SRAN)
      return (shamt == 4'd0) ? 5'd1 : {1'b0, shamt};
    if (op == OP_MUL)
      return 5'd16;
    return 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = OP_ADD;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = op_legal(req_op) ? EXEC : DONE;
      end
      EXEC: begin
        if (cnt == 5'd1) state_nxt = DONE;
        case (cmd)
          OP_SLLN, OP_SRAN: begin
            alu_a = w;
            if (opb[3:0] == 4'd0) alu_op = OP_ADD;
            else                  alu_op = (cmd == OP_SLLN) ? OP_SLL1 : OP_SRA1;
          end
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: begin
            alu_a  = w;
            alu_b  = opb;
            alu_op = OP_ADD;
          end
`endif
          default: begin
            alu_a  = w;
            alu_b  = opb;
            alu_op = cmd;
          end
        endcase
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_nxt = alu_ans;
`ifdef ALU_SEQ_MUL_EN
    if (cmd == OP_MUL && !q[0]) w_nxt = w;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= '0;
      w        <= '0;
      opb      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd      <= req_op;
            w        <= req_a;
            opb      <= req_b;
            cnt      <= op_iters(req_op, req_b[3:0]);
            rsp_data <= '0;
            rsp_err  <= !op_legal(req_op);
`ifdef ALU_SEQ_MUL_EN
            if (req_op == OP_MUL) begin
              w   <= '0;
              opb <= req_a;
              q   <= req_b;
            end
`endif
          end
        end
        EXEC: begin
          cnt <= cnt - 5'd1;
          w   <= w_nxt;
`ifdef ALU_SEQ_MUL_EN
          if (cmd == OP_MUL) begin
            opb <= opb << 1;
            q   <= q >> 1;
          end
`endif
          if (cnt == 5'd1) rsp_data <= w_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: vector table plus scoreboard bench for alu_sequencer, with a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [3:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_data, alu_a, alu_b, alu_ans;
  logic [3:0]  alu_op;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ans(alu_ans)
  );

  always_comb begin
    case (alu_op)
      4'd0:    alu_ans = alu_a + alu_b;
      4'd1:    alu_ans = alu_a - alu_b;
      4'd2:    alu_ans = alu_a & alu_b;
      4'd3:    alu_ans = alu_a | alu_b;
      4'd4:    alu_ans = alu_a ^ alu_b;
      4'd5:    alu_ans = ~alu_a;
      4'd6:    alu_ans = {alu_a[14:0], 1'b0};
      4'd7:    alu_ans = {alu_a[15], alu_a[15:1]};
      default: alu_ans = 16'h0000;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] d, input logic e, input int l);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.data = d; v.err = e; v.lat = l;
    tbl.push_back(v);
  endtask

  // Called #1 after the accepting edge; returns the edge count at which rsp_valid is sampled high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'h3; req_a = 16'h5A5A; req_b = 16'hFFFF;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    exp_t e;
    issue(v.op, v.a, v.b);
    e.data = v.data; e.err = v.err;
    sb.push_back(e);
    wait_rsp(lat);
    check($sformatf("v%0d latency", idx), lat, v.lat);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("v%0d rsp_data", idx), rsp_data, e.data);
      check($sformatf("v%0d rsp_err", idx), rsp_err, e.err);
    end
    check($sformatf("v%0d ready_in_done", idx), req_ready, 1'b0);
    check($sformatf("v%0d alu_op_in_done", idx), alu_op, 4'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check($sformatf("v%0d ready_after", idx), req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    exp_t e;
    logic [15:0] held;

    add(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 2);
    add(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2);
    add(4'd1,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 2);
    add(4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 2);
    add(4'd3,  16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 2);
    add(4'd4,  16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 2);
    add(4'd5,  16'h1234, 16'h0000, 16'hEDCB, 1'b0, 2);
    add(4'd6,  16'h8001, 16'h0000, 16'h0002, 1'b0, 2);
    add(4'd7,  16'h8002, 16'h0000, 16'hC001, 1'b0, 2);
    add(4'd9,  16'h8001, 16'h0003, 16'hF000, 1'b0, 4);
    add(4'd8,  16'h1234, 16'h0000, 16'h1234, 1'b0, 2);
    add(4'd8,  16'h0ABC, 16'hFFF4, 16'hABC0, 1'b0, 5);
    add(4'd9,  16'h7FF0, 16'h0004, 16'h07FF, 1'b0, 5);
    add(4'd8,  16'h0001, 16'h000F, 16'h8000, 1'b0, 16);
    add(4'd13, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1);
    add(4'd11, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1);
    add(4'd15, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
    add(4'd10, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 17);
    add(4'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17);
`else
    add(4'd10, 16'h0123, 16'h0045, 16'h0000, 1'b1, 1);
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset req_ready", req_ready, 1'b1);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_data", rsp_data, 16'h0000);
    check("reset rsp_err", rsp_err, 1'b0);
    check("reset alu_outs", {alu_a, alu_b, alu_op}, 36'h0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset during the 5th EXEC cycle of a 15-step shift, with req_valid also high.
    issue(4'd8, 16'h0001, 16'h000F);
    repeat (4) @(posedge clk);
    #1;
    check("midexec alu_a", alu_a, 16'h0010);
    check("midexec alu_op", alu_op, 4'd6);
    rst = 1'b1; req_valid = 1'b1; req_op = 4'd0; req_a = 16'h0001; req_b = 16'h0001;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    check("midexec req_ready", req_ready, 1'b1);
    check("midexec rsp_valid", rsp_valid, 1'b0);
    check("midexec rsp_data", rsp_data, 16'h0000);
    check("midexec rsp_err", rsp_err, 1'b0);
    check("midexec alu_outs", {alu_a, alu_b, alu_op}, 36'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("midexec no_rsp", rsp_valid, 1'b0);
    end

    // Response held for 10 cycles while a second request is presented.
    issue(4'd4, 16'h00FF, 16'h0F0F);
    e.data = 16'h0FF0; e.err = 1'b0;
    sb.push_back(e);
    wait_rsp(lat);
    check("hold latency", lat, 2);
    e = sb.pop_front();
    check("hold rsp_data", rsp_data, e.data);
    held = rsp_data;
    req_op = 4'd0; req_a = 16'h0001; req_b = 16'h0001; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold rsp_valid", rsp_valid, 1'b1);
      check("hold stable", rsp_data, held);
      check("hold req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold release", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hold not_queued", rsp_valid, 1'b0);
    end

    // rsp_ready held high throughout: ignored until DONE, then consumed at once.
    rsp_ready = 1'b1;
    issue(4'd8, 16'h0003, 16'h0005);
    e.data = 16'h0060; e.err = 1'b0;
    sb.push_back(e);
    wait_rsp(lat);
    check("early_ready latency", lat, 6);
    e = sb.pop_front();
    check("early_ready rsp_data", rsp_data, e.data);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("early_ready consumed", rsp_valid, 1'b0);
    check("early_ready req_ready", req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
